// File: rtl/nanosoc_busmatrix_pkg.sv
// rtl/nanosoc_busmatrix_pkg.sv - shared AHB encodings and helpers for the nanosoc bus matrix
package nanosoc_busmatrix_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BUR_SINGLE = 3'b000,
    BUR_INCR   = 3'b001,
    BUR_WRAP4  = 3'b010,
    BUR_INCR4  = 3'b011,
    BUR_WRAP8  = 3'b100,
    BUR_INCR8  = 3'b101,
    BUR_WRAP16 = 3'b110,
    BUR_INCR16 = 3'b111
  } hburst_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Beats remaining after the NONSEQ beat; undefined-length bursts never hold.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      BUR_INCR16, BUR_WRAP16: return 4'd15;
      BUR_INCR8,  BUR_WRAP8:  return 4'd7;
      BUR_INCR4,  BUR_WRAP4:  return 4'd3;
      BUR_SINGLE, BUR_INCR:   return 4'd0;
      default:                return 4'bxxxx;
    endcase
  endfunction

endpackage

// File: rtl/nanosoc_arb_rr_pick.sv
// rtl/nanosoc_arb_rr_pick.sv - rotate-and-priority-encode picker starting from a given port
module nanosoc_arb_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    start,
  output logic                 valid,
  output logic [PORT_W-1:0]    idx
);

  localparam int PW1 = PORT_W + 1;
  localparam logic [PORT_W:0] NUM_P = PW1'(NUM_PORTS);

  logic [PORT_W:0] pos;

  // Scan from the far end so the port nearest to start makes the final, winning assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = {1'b0, start} + PW1'(k);
      if (pos >= NUM_P) begin
        pos = pos - NUM_P;
      end
      if (req[pos[PORT_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[PORT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/nanosoc_arbiter_param.sv
// rtl/nanosoc_arbiter_param.sv - output-stage arbiter selecting which input port drives a shared slave
import nanosoc_busmatrix_pkg::*;

module nanosoc_arbiter_param #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = $clog2(NUM_PORTS),
  parameter int EARLY_TERM_MAX = 2,
  parameter int INCR_MAX_BEATS = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 arb_mode,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam int INCR_W = (INCR_MAX_BEATS < 2) ? 1 : $clog2(INCR_MAX_BEATS + 1);
  localparam logic [INCR_W-1:0] INCR_CAP = INCR_W'(INCR_MAX_BEATS);
  localparam logic [INCR_W-1:0] INCR_ONE = INCR_W'(1);
  localparam bit                CAP_EN   = (INCR_MAX_BEATS != 0);
  localparam logic [1:0]        ET_MAX   = 2'(EARLY_TERM_MAX);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  logic [3:0]           burst_cnt, cnt_nxt;
  logic                 hold_nxt;
  logic [1:0]           early_cnt, early_nxt;
  logic [INCR_W-1:0]    incr_cnt, incr_nxt;
  logic [PORT_W-1:0]    rr_ptr, ptr_nxt, rr_next;
  logic [PORT_W-1:0]    port_nxt;
  logic                 no_port_nxt;

  logic                 nonseq_sel;
  logic [NUM_PORTS-1:0] cur_onehot;
  logic                 other_req;
  logic                 cap_trip;
  logic                 continuing;
  logic                 mode_rr;
  logic [NUM_PORTS-1:0] pick_req;
  logic [PORT_W-1:0]    pick_start;
  logic                 pick_valid;
  logic [PORT_W-1:0]    pick_idx;

  assign nonseq_sel = HSELM && (HTRANSM == TRN_NONSEQ);
  assign mode_rr    = (arb_mode == ARB_RR);
  assign cur_onehot = NUM_PORTS'(1) << addr_in_port;
  assign other_req  = |(req_port & ~cur_onehot);
  assign rr_next    = (rr_ptr == LAST_PORT) ? '0 : rr_ptr + PORT_W'(1);

  always_comb begin
    cnt_nxt   = burst_cnt;
    hold_nxt  = burst_hold;
    incr_nxt  = incr_cnt;
    early_nxt = early_cnt;
    if (!HSELM) begin
      cnt_nxt  = '0;
      hold_nxt = 1'b0;
      incr_nxt = '0;
    end else begin
      case (HTRANSM)
        TRN_IDLE: begin
          cnt_nxt  = '0;
          hold_nxt = 1'b0;
          incr_nxt = '0;
        end
        TRN_BUSY: begin
        end
        TRN_NONSEQ: begin
          cnt_nxt  = burst_beats(HBURSTM);
          hold_nxt = (burst_beats(HBURSTM) != 4'd0);
          incr_nxt = (HBURSTM == BUR_INCR) ? INCR_ONE : '0;
        end
        TRN_SEQ: begin
          if (burst_cnt != 4'd0) cnt_nxt = burst_cnt - 4'd1;
          if (burst_cnt == 4'd1) hold_nxt = 1'b0;
          if (incr_cnt != '0 && incr_cnt < INCR_CAP) incr_nxt = incr_cnt + INCR_ONE;
        end
        default: begin
          cnt_nxt  = 'x;
          hold_nxt = 1'bx;
          incr_nxt = 'x;
        end
      endcase
    end
    // Too many back-to-back early terminations: stop honouring the new burst's hold.
    if (nonseq_sel && early_cnt == ET_MAX) begin
      cnt_nxt  = '0;
      hold_nxt = 1'b0;
    end
    if (!hold_nxt) begin
      early_nxt = '0;
    end else if (nonseq_sel && burst_hold && early_cnt < ET_MAX) begin
      early_nxt = early_cnt + 2'd1;
    end
  end

  assign cap_trip   = CAP_EN && (incr_nxt >= INCR_CAP) && other_req && !HMASTLOCKM;
  assign continuing = HSELM && (HTRANSM != TRN_IDLE) && !cap_trip;

  // Fixed mode folds the continuing owner into the request vector and scans from port 0.
  assign pick_req   = mode_rr ? req_port : (req_port | (continuing ? cur_onehot : '0));
  assign pick_start = (arb_mode == ARB_FIXED) ? '0 : rr_next;

  nanosoc_arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    port_nxt    = addr_in_port;
    no_port_nxt = no_port;
    ptr_nxt     = rr_ptr;
    if (HMASTLOCKM || hold_nxt) begin
      no_port_nxt = 1'b0;
    end else if (mode_rr && continuing) begin
      no_port_nxt = 1'b0;
    end else if (pick_valid) begin
      port_nxt    = pick_idx;
      no_port_nxt = 1'b0;
      if (req_port[pick_idx] && (pick_idx != addr_in_port || no_port)) begin
        ptr_nxt = pick_idx;
      end
    end else if (HSELM) begin
      no_port_nxt = 1'b0;
    end else begin
      no_port_nxt = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      burst_hold   <= 1'b0;
      burst_cnt    <= '0;
      early_cnt    <= '0;
      incr_cnt     <= '0;
      rr_ptr       <= LAST_PORT;
    end else if (HREADYM) begin
      addr_in_port <= port_nxt;
      no_port      <= no_port_nxt;
      burst_hold   <= hold_nxt;
      burst_cnt    <= cnt_nxt;
      early_cnt    <= early_nxt;
      incr_cnt     <= incr_nxt;
      rr_ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_nanosoc_arbiter_param.sv
// tb/tb_nanosoc_arbiter_param.sv - directed and randomized bench for the output-stage arbiter
module tb_nanosoc_arbiter_param;

  localparam int N   = 4;
  localparam int ETM = 2;
  localparam int CAP = 4;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] req_port;
  logic       arb_mode, HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [1:0] addr_in_port;
  logic       no_port, burst_hold;

  int checks = 0;
  int failures = 0;

  int m_port, m_left, m_early, m_incr, m_ptr;
  bit m_none, m_hold;

  nanosoc_arbiter_param #(
    .NUM_PORTS      (N),
    .EARLY_TERM_MAX (ETM),
    .INCR_MAX_BEATS (CAP)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .arb_mode     (arb_mode),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .burst_hold   (burst_hold)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_port = 0; m_none = 1; m_hold = 0; m_left = 0; m_early = 0; m_incr = 0; m_ptr = N - 1;
  endtask

  // Next owner from the arbitration rules, evaluated on the inputs currently driven.
  task automatic model_update();
    int  left, early, incr, win;
    bit  hold, nonseq, others, trip, cont;
    if (!HREADYM) return;
    nonseq = HSELM && HTRANSM == T_NSEQ;
    left = m_left; hold = m_hold; incr = m_incr;
    if (!HSELM || HTRANSM == T_IDLE) begin
      left = 0; hold = 0; incr = 0;
    end else if (HTRANSM == T_NSEQ) begin
      left = beats_of(HBURSTM) - 1;
      hold = (left > 0);
      incr = (HBURSTM == B_INCR) ? 1 : 0;
    end else if (HTRANSM == T_SEQ) begin
      if (m_left == 1) hold = 0;
      left = (m_left > 0) ? m_left - 1 : 0;
      if (m_incr > 0 && m_incr < CAP) incr = m_incr + 1;
    end
    if (nonseq && m_early == ETM) begin
      left = 0; hold = 0;
    end
    if (!hold) early = 0;
    else if (nonseq && m_hold) early = (m_early < ETM) ? m_early + 1 : ETM;
    else early = m_early;
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_port && req_port[i]) others = 1;
    trip = (CAP > 0) && (incr >= CAP) && others && !HMASTLOCKM;
    cont = HSELM && HTRANSM != T_IDLE && !trip;
    if (HMASTLOCKM || hold) begin
      m_none = 0;
    end else begin
      win = -1;
      if (arb_mode == 1'b0) begin
        for (int i = 0; i < N; i++)
          if (win < 0 && (req_port[i] || (i == m_port && cont))) win = i;
      end else if (cont) begin
        win = m_port;
      end else begin
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_port[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        if (req_port[win] && (win != m_port || m_none) && !(arb_mode && cont)) m_ptr = win;
        m_port = win;
        m_none = 0;
      end else begin
        m_none = !HSELM;
      end
    end
    m_left = left; m_hold = hold; m_early = early; m_incr = incr;
  endtask

  task automatic drive(input logic [3:0] r, input logic m, input logic rdy, input logic s,
                       input logic [1:0] t, input logic [2:0] b, input logic l);
    req_port = r; arb_mode = m; HREADYM = rdy; HSELM = s; HTRANSM = t; HBURSTM = b; HMASTLOCKM = l;
  endtask

  task automatic step();
    model_update();
    @(posedge HCLK);
    #1;
    chk("model_addr", 32'(addr_in_port), 32'(m_port));
    chk("model_no_port", 32'(no_port), 32'(m_none));
    chk("model_hold", 32'(burst_hold), 32'(m_hold));
  endtask

  task automatic pulse_reset(input string tag);
    #2 HRESETn = 1'b0;
    #1;
    chk({tag, "_addr"}, 32'(addr_in_port), 0);
    chk({tag, "_no_port"}, 32'(no_port), 1);
    chk({tag, "_hold"}, 32'(burst_hold), 0);
    #2 HRESETn = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_order [4] = '{1, 2, 3, 0};
    int prev;
    drive(4'b0000, 1'b0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    model_reset();
    #12;
    chk("rst_addr", 32'(addr_in_port), 0);
    chk("rst_no_port", 32'(no_port), 1);
    chk("rst_hold", 32'(burst_hold), 0);
    HRESETn = 1'b1;

    drive(4'b0110, 1'b0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    chk("fixed_first_addr", 32'(addr_in_port), 1);
    chk("fixed_first_no_port", 32'(no_port), 0);

    drive(4'b0100, 1'b0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    chk("incr4_owner", 32'(addr_in_port), 2);
    drive(4'b0101, 1'b0, 1'b1, 1'b1, T_NSEQ, B_INCR4, 1'b0); step();
    chk("incr4_nseq_addr", 32'(addr_in_port), 2);
    chk("incr4_nseq_hold", 32'(burst_hold), 1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0101, 1'b0, 1'b1, 1'b1, T_SEQ, B_INCR4, 1'b0); step();
      chk("incr4_seq_addr", 32'(addr_in_port), (i < 2) ? 2 : 0);
      chk("incr4_seq_hold", 32'(burst_hold), (i < 2) ? 1 : 0);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();

    pulse_reset("rr_rst");
    drive(4'b1111, 1'b1, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    chk("rr_grant0", 32'(addr_in_port), 0);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, 1'b1, 1'b1, 1'b1, T_NSEQ, B_SINGLE, 1'b0); step();
      chk("rr_keep", 32'(addr_in_port), 32'(prev));
      drive(4'b1111, 1'b1, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0); step();
      chk("rr_order", 32'(addr_in_port), 32'(exp_order[i]));
      prev = exp_order[i];
    end

    for (int j = 0; j < 3; j++) begin
      drive(4'b1000, 1'b0, 1'b1, 1'b1, T_NSEQ, B_INCR8, 1'b0); step();
      chk("early_nseq_hold", 32'(burst_hold), 1);
      drive(4'b1000, 1'b0, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0); step();
      chk("early_seq_hold", 32'(burst_hold), 1);
    end
    drive(4'b1000, 1'b0, 1'b1, 1'b1, T_NSEQ, B_INCR8, 1'b0); step();
    chk("early_release_hold", 32'(burst_hold), 0);
    chk("early_release_addr", 32'(addr_in_port), 0);
    drive(4'b1000, 1'b0, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0); step();
    chk("early_port3", 32'(addr_in_port), 3);

    drive(4'b0010, 1'b1, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    chk("cap_owner", 32'(addr_in_port), 1);
    for (int b = 1; b <= 4; b++) begin
      drive(4'b0011, 1'b1, 1'b1, 1'b1, (b == 1) ? T_NSEQ : T_SEQ, B_INCR, 1'b0); step();
      chk("cap_beat_addr", 32'(addr_in_port), (b < 4) ? 1 : 0);
    end
    drive(4'b0010, 1'b1, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    chk("lock_owner", 32'(addr_in_port), 1);
    for (int b = 1; b <= 10; b++) begin
      drive(4'b0011, 1'b1, 1'b1, 1'b1, (b == 1) ? T_NSEQ : T_SEQ, B_INCR, 1'b1); step();
      chk("lock_beat_addr", 32'(addr_in_port), 1);
    end
    drive(4'b0000, 1'b1, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();

    drive(4'b0100, 1'b0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, T_IDLE, B_SINGLE, 1'b0); step();
      chk("freeze_addr", 32'(addr_in_port), 2);
      chk("freeze_no_port", 32'(no_port), 0);
    end
    drive(4'b0100, 1'b0, 1'b1, 1'b1, T_NSEQ, B_INCR16, 1'b0); step();
    drive(4'b0100, 1'b0, 1'b1, 1'b1, T_SEQ, B_INCR16, 1'b0); step();
    chk("midburst_hold", 32'(burst_hold), 1);
    pulse_reset("midburst_rst");

    for (int c = 0; c < 1500; c++) begin
      int r;
      if (c % 50 == 0) arb_mode = ~arb_mode;
      req_port   = 4'($urandom_range(0, 15));
      HREADYM    = ($urandom_range(0, 3) != 0);
      HSELM      = ($urandom_range(0, 3) != 0);
      HBURSTM    = 3'($urandom_range(0, 7));
      HMASTLOCKM = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 9));
      HTRANSM = (r < 2) ? T_IDLE : (r == 2) ? T_BUSY : (r < 5) ? T_NSEQ : T_SEQ;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nanosoc_arbiter_param.md
Name: nanosoc_arbiter_param

Overview:
- Parametrised output-stage arbiter for the nanosoc bus matrix, one instance per shared slave port.
- Selects which of NUM_PORTS input stages drives the slave's address phase.
- Tracks fixed-length burst boundaries and honours locked transfers.
- Adds three things the fixed 4-port arbiter lacks:
  - runtime-selectable fixed-priority or round-robin arbitration;
  - a configurable early-termination limit;
  - a beat cap on undefined-length INCR bursts.

Parameters:
- NUM_PORTS, 4, number of input ports (2..16).
- PORT_W, $clog2(NUM_PORTS), width of the port index (derived; do not override).
- EARLY_TERM_MAX, 2, number of consecutive early-terminated fixed bursts before burst hold is ignored (1..3).
- INCR_MAX_BEATS, 16, maximum beats an INCR burst holds the port while another port requests; 0 disables the cap.

Ports:
- HCLK  in  1  AHB system clock.
- HRESETn  in  1  asynchronous active-low reset.
- req_port  in  NUM_PORTS  per-port request; bit i set = input port i requests this slave.
- arb_mode  in  1  0 = fixed priority (port 0 highest), 1 = round robin; quasi-static.
- HREADYM  in  1  transfer done on the slave side.
- HSELM  in  1  slave select of the current owner.
- HTRANSM  in  2  transfer type.
- HBURSTM  in  3  burst type.
- HMASTLOCKM  in  1  locked transfer.
- addr_in_port  out  PORT_W  index of the selected input port (registered).
- no_port  out  1  no input port selected (registered).
- burst_hold  out  1  registered burst-hold flag, for debug and coverage.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous, active-low.
- Reset values:
  - addr_in_port = 0, no_port = 1, burst_hold = 0;
  - burst count = 0, early-term count = 0, INCR beat count = 0;
  - round-robin pointer = NUM_PORTS-1, so port 0 wins first.
- Register update: all state registers load only when HREADYM = 1; otherwise they hold.
- Burst counter, next-value logic:
  - HSELM = 0: count = 0, hold = 0.
  - NONSEQ, 16-beat burst: count = 15, hold = 1.
  - NONSEQ, 8-beat burst: count = 7, hold = 1.
  - NONSEQ, 4-beat burst: count = 3, hold = 1.
  - NONSEQ, SINGLE or INCR: count = 0, hold = 0.
  - SEQ: count decrements; hold clears when count = 1.
  - BUSY: count and hold unchanged.
  - IDLE: count = 0, hold = 0.
  - Count is 4-bit and never wraps below 0; SEQ at count 0 holds 0.
- Early termination:
  - A NONSEQ while registered hold = 1 increments the early-term count, saturating.
  - The count clears whenever next hold = 0.
  - A NONSEQ seen with count = EARLY_TERM_MAX forces next hold = 0 and next count = 0.
- INCR cap:
  - The beat counter starts at 1 on NONSEQ with HBURSTM = INCR.
  - It increments on SEQ and clears on IDLE, NONSEQ or HSELM = 0.
  - When it reaches INCR_MAX_BEATS and any other port requests, the owner loses its continuation right (below) for that cycle.
  - HMASTLOCKM overrides the cap.
- Next-selection priority (combinational, applied on HREADYM):
  1. HMASTLOCKM = 1 or next hold = 1: keep the current port.
  2. Continuation: the current port is continuing if HSELM = 1, HTRANSM is not IDLE, and the INCR cap has not tripped.
  3. Fixed mode: the lowest index i with req_port[i] = 1, or i = current port and continuing, wins.
  4. Round-robin mode: a continuing current port is kept. Otherwise the first requesting port at or after pointer+1, modulo NUM_PORTS, wins.
  5. No winner and HSELM = 1: keep the current port with no_port = 0.
  6. No winner and HSELM = 0: no_port = 1 and addr_in_port is unchanged.
- Round-robin pointer: loads the granted index whenever a requesting port is newly granted. It is updated in both modes, so switching arb_mode is glitch-free.
- Latency: a request reaches addr_in_port one HCLK after the first HREADYM = 1 cycle that grants it.
- X-propagation: reserved HBURSTM or HTRANSM encodings drive X on next-state values, for simulation only.

Decomposition:
- nanosoc_busmatrix_pkg holds:
  - HTRANS encodings TRN_IDLE, TRN_BUSY, TRN_NONSEQ, TRN_SEQ;
  - HBURST encodings BUR_SINGLE through BUR_INCR16;
  - ARB_FIXED and ARB_RR mode constants;
  - a function burst_beats(hburst) returning the initial count.
- One sub-module: nanosoc_arb_rr_pick, a combinational rotate-and-priority-encode over NUM_PORTS from a start index, returning a valid flag and an index.

Test Plan:
- Reset, then fixed mode with req_port = 4'b0110 and HSELM = 0 → after 1 cycle addr_in_port = 1, no_port = 0.
- Port 2 owns the slave and issues NONSEQ INCR4, then 3 SEQ, with req_port[0] = 1 throughout → addr_in_port stays 2 for all 4 beats (burst_hold = 1) and switches to 0 on the beat after the last SEQ.
- Round-robin mode, all 4 ports requesting, each issuing single IDLE-terminated transfers → grant order 0, 1, 2, 3, 0.
- EARLY_TERM_MAX = 2, owner issues NONSEQ INCR8, then a NONSEQ every second beat, with req_port[3] = 1 → hold released on the 3rd NONSEQ, and port 3 granted next cycle.
- INCR_MAX_BEATS = 4, port 1 issues an INCR of 10 beats while port 0 requests (arb_mode = 1) → port 0 granted after beat 4. Repeat with HMASTLOCKM = 1 → port 1 keeps all 10 beats.
- HREADYM = 0 for 3 cycles while req_port changes → addr_in_port and no_port frozen. Assert HRESETn low mid-burst → no_port = 1, addr_in_port = 0, burst_hold = 0 immediately.
